menu_select: RTL and testbench

MENU_SELECT -- requirements
Module: menu_select

---
 rtl/menu_select.sv | 175 +++++++++++++++++
 tb/tb_menu_select.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/menu_select.sv
`default_nettype none
// ============================================================================
// Module   : menu_select
// Purpose  : Debounced three-button menu navigator. Up/Down move the
//            highlighted item (1..NUM_ITEMS, wrapping) while the top level
//            sits in the menu; Centre produces a one-cycle select strobe.
// Options  : define MENU_AUTOREPEAT_EN to build in hold-to-repeat for Up/Down.
// Revision : 1.0  initial release
// ============================================================================
module menu_select #(
   parameter int NUM_ITEMS   = 4,
   parameter int DB_CYCLES   = 100000,
   parameter int HOLD_CYCLES = 25000000,
   parameter int RPT_CYCLES  = 10000000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       btnU,
   input  logic       btnD,
   input  logic       btnC,
   input  logic [2:0] state,
   output logic [2:0] menu_flag,
   output logic       sel_pulse,
   output logic       move_pulse
);

   localparam int         c_DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
   localparam logic [2:0] c_NUM  = 3'(NUM_ITEMS);
   localparam int         c_BU   = 0;
   localparam int         c_BD   = 1;
   localparam int         c_BC   = 2;

   typedef enum logic [0:0] {
      NAV    = 1'b0,
      FROZEN = 1'b1
   } nav_state_t;

   // Elaboration-time sanity checks on the configuration
   if (NUM_ITEMS < 1 || NUM_ITEMS > 7) begin : g_bad_num_items
      $error("menu_select: NUM_ITEMS must be in 1..7");
   end
   if (DB_CYCLES < 1 || HOLD_CYCLES < 1 || RPT_CYCLES < 1) begin : g_bad_timing
      $error("menu_select: DB/HOLD/RPT cycle counts must be at least 1");
   end

   logic [2:0] w_raw;
   logic [2:0] r_sync1;
   logic [2:0] r_sync2;
   logic [2:0] w_deb;
   logic [2:0] r_deb_q;
   logic [2:0] r_ev;
   nav_state_t r_fsm;
   logic       w_rpt_up;
   logic       w_rpt_dn;
   logic       w_up;
   logic       w_dn;
   logic       w_sel;
   logic       w_move;

   assign w_raw = {btnC, btnD, btnU};

   // Two-flop synchronizers bring the asynchronous buttons into the clk domain
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_sync1 <= 3'b000;
         r_sync2 <= 3'b000;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
      logic [c_DB_W-1:0] r_cnt;
      logic              r_lvl;

      // Accept a new level only after it has been stable for DB_CYCLES; any
      // agreeing cycle restarts the count so short glitches are ignored
      always_ff @(posedge clk) begin
         if (!rstn) begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
         end else if (r_sync2[gi] == r_lvl) begin
            r_cnt <= '0;
         end else if (r_cnt == c_DB_W'(DB_CYCLES - 1)) begin
            r_cnt <= '0;
            r_lvl <= ~r_lvl;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign w_deb[gi] = r_lvl;
   end

   // Registered rising-edge detect: one press event per debounced 0->1
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_deb_q <= 3'b000;
         r_ev    <= 3'b000;
      end else begin
         r_deb_q <= w_deb;
         r_ev    <= w_deb & ~r_deb_q;
      end
   end

`ifdef MENU_AUTOREPEAT_EN
   localparam int c_RPT_MAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
   localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);

   logic [c_RPT_W-1:0] r_rpt_cnt;
   logic               r_rpt_phase;
   logic [1:0]         r_rpt_ev;
   logic               w_rpt_act;
   logic [c_RPT_W-1:0] w_rpt_lim;

   // Repeat only while exactly one direction is held and the menu is live.
   // The hold limit is one larger than the repeat limit because the first
   // move already trails the debounced edge by the registered event stage.
   assign w_rpt_act = (r_fsm == NAV) && (w_deb[c_BU] ^ w_deb[c_BD]);
   assign w_rpt_lim = r_rpt_phase ? c_RPT_W'(RPT_CYCLES - 1) : c_RPT_W'(HOLD_CYCLES);

   // Hold-then-repeat timer emitting synthetic Up/Down events
   always_ff @(posedge clk) begin
      if (!rstn || !w_rpt_act) begin
         r_rpt_cnt   <= '0;
         r_rpt_phase <= 1'b0;
         r_rpt_ev    <= 2'b00;
      end else if (r_rpt_cnt == w_rpt_lim) begin
         r_rpt_cnt   <= '0;
         r_rpt_phase <= 1'b1;
         r_rpt_ev    <= w_deb[1:0];
      end else begin
         r_rpt_cnt   <= r_rpt_cnt + 1'b1;
         r_rpt_ev    <= 2'b00;
      end
   end

   assign w_rpt_up = r_rpt_ev[c_BU];
   assign w_rpt_dn = r_rpt_ev[c_BD];
`else
   assign w_rpt_up = 1'b0;
   assign w_rpt_dn = 1'b0;
`endif

   // A select in the same cycle wins over a move so the item latched with
   // sel_pulse is the one that was highlighted when Centre was pressed
   assign w_up   = r_ev[c_BU] | w_rpt_up;
   assign w_dn   = r_ev[c_BD] | w_rpt_dn;
   assign w_sel  = r_ev[c_BC];
   assign w_move = (r_fsm == NAV) && (w_up ^ w_dn) && !w_sel && (c_NUM > 3'd1);

   // Navigation FSM and registered outputs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_fsm      <= NAV;
         menu_flag  <= 3'd1;
         sel_pulse  <= 1'b0;
         move_pulse <= 1'b0;
      end else begin
         r_fsm      <= (state == 3'd0) ? NAV : FROZEN;
         sel_pulse  <= w_sel;
         move_pulse <= w_move;
         if (w_move) begin
            if (w_up) begin
               menu_flag <= (menu_flag <= 3'd1) ? c_NUM : menu_flag - 3'd1;
            end else begin
               menu_flag <= (menu_flag >= c_NUM) ? 3'd1 : menu_flag + 3'd1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_menu_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_select
// Purpose  : Self-checking bench for menu_select with a pulse scoreboard.
//            Expectations follow MENU_AUTOREPEAT_EN when it is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_menu_select;

   localparam int NUM  = 4;
   localparam int DB   = 4;
   localparam int HOLD = 10;
   localparam int RPT  = 5;

   logic       clk   = 1'b0;
   logic       rstn  = 1'b0;
   logic       btnU  = 1'b0;
   logic       btnD  = 1'b0;
   logic       btnC  = 1'b0;
   logic [2:0] state = 3'd0;
   logic [2:0] menu_flag, menu_flag1;
   logic       sel_pulse, move_pulse, sel_pulse1, move_pulse1;

   menu_select #(.NUM_ITEMS(NUM), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT)) dut (
      .clk(clk), .rstn(rstn), .btnU(btnU), .btnD(btnD), .btnC(btnC), .state(state),
      .menu_flag(menu_flag), .sel_pulse(sel_pulse), .move_pulse(move_pulse));

   menu_select #(.NUM_ITEMS(1), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT)) dut1 (
      .clk(clk), .rstn(rstn), .btnU(btnU), .btnD(btnD), .btnC(btnC), .state(state),
      .menu_flag(menu_flag1), .sel_pulse(sel_pulse1), .move_pulse(move_pulse1));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit is_sel;
      int cyc;
      int flag;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total     = 0;
   int   bad       = 0;
   int   exp_flag  = 1;
   int   n_sel     = 0;
   int   sel_cnt1  = 0;
   int   move_cnt1 = 0;
   int   range_err = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int step(input int f, input bit up);
      if (NUM <= 1) return 1;
      if (up) return (f == 1) ? NUM : f - 1;
      return (f == NUM) ? 1 : f + 1;
   endfunction

   task automatic push(input bit s, input int c, input int f);
      exp_t e;
      e.is_sel = s;
      e.cyc    = c;
      e.flag   = f;
      sb.push_back(e);
   endtask

   // cdu = {btnC, btnD, btnU}; c is the index of the edge just passed
   task automatic drive(input logic [2:0] cdu, output int c);
      @(posedge clk);
      #1;
      {btnC, btnD, btnU} = cdu;
      c = cyc;
   endtask

   task automatic release_after(input int hold);
      repeat (hold) @(posedge clk);
      #1;
      {btnC, btnD, btnU} = 3'b000;
      repeat (DB + 8) @(posedge clk);
   endtask

   task automatic press_move(input bit up);
      int c;
      drive(up ? 3'b001 : 3'b010, c);
      exp_flag = step(exp_flag, up);
      push(1'b0, c + DB + 4, exp_flag);
      release_after(8);
   endtask

   // Scoreboard consumer and continuous invariants
   always @(negedge clk) begin
      if (sel_pulse) begin
         if (sb.size() == 0) check_val("unexpected sel_pulse at cycle", cyc, -1);
         else begin
            mon_e = sb.pop_front();
            check_val("sel pulse kind", 1, mon_e.is_sel ? 1 : 0);
            check_val("sel cycle", cyc, mon_e.cyc);
            check_val("flag at sel", int'(menu_flag), mon_e.flag);
         end
      end
      if (move_pulse) begin
         if (sb.size() == 0) check_val("unexpected move_pulse at cycle", cyc, -1);
         else begin
            mon_e = sb.pop_front();
            check_val("move pulse kind", 0, mon_e.is_sel ? 1 : 0);
            check_val("move cycle", cyc, mon_e.cyc);
            check_val("flag after move", int'(menu_flag), mon_e.flag);
         end
      end
      if (menu_flag == 3'd0 || menu_flag > 3'(NUM)) range_err++;
      if (menu_flag1 != 3'd1) range_err++;
      if (move_pulse1) move_cnt1++;
      if (sel_pulse1)  sel_cnt1++;
   end

   initial begin
      int c;
      int base;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check_val("reset menu_flag", int'(menu_flag), 1);
      check_val("reset sel_pulse", int'(sel_pulse), 0);
      check_val("reset move_pulse", int'(move_pulse), 0);
      rstn = 1'b1;

      // Wrap both ways, then a plain Down
      press_move(1'b1);
      press_move(1'b0);
      press_move(1'b0);

      // Bounce on Down never settles long enough
      #1;
      for (int i = 0; i < 5; i++) begin
         btnD = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         btnD = 1'b0;
         @(posedge clk);
         #1;
      end
      repeat (DB + 10) @(posedge clk);
      check_val("flag after bounce", int'(menu_flag), exp_flag);

      // Frozen: presses are dropped, not queued
      state = 3'd3;
      repeat (2) @(posedge clk);
      drive(3'b010, c);
      release_after(8);
      drive(3'b010, c);
      release_after(8);
      state = 3'd0;
      repeat (DB + 10) @(posedge clk);
      check_val("flag after freeze", int'(menu_flag), exp_flag);

      // Navigation resumes normally
      press_move(1'b0);

      // Centre together with Down: select only
      drive(3'b110, c);
      push(1'b1, c + DB + 4, exp_flag);
      n_sel++;
      release_after(8);

      // Up together with Down: nothing
      drive(3'b011, c);
      release_after(8);
      check_val("flag after up+down", int'(menu_flag), exp_flag);

      // Centre is honoured while an app runs
      state = 3'd5;
      repeat (2) @(posedge clk);
      drive(3'b100, c);
      push(1'b1, c + DB + 4, exp_flag);
      n_sel++;
      release_after(8);
      state = 3'd0;
      repeat (2) @(posedge clk);

      // Reset mid-debounce; the still-held button counts as a fresh press
      drive(3'b010, c);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("flag after mid-debounce reset", int'(menu_flag), 1);
      exp_flag = 1;
      rstn = 1'b1;
      c = cyc;
      exp_flag = step(exp_flag, 1'b0);
      push(1'b0, c + DB + 4, exp_flag);
      release_after(8);

      // Long hold on Down
      drive(3'b010, c);
      base = c + DB + 4;
      exp_flag = step(exp_flag, 1'b0);
      push(1'b0, base, exp_flag);
`ifdef MENU_AUTOREPEAT_EN
      for (int k = 0; k < 4; k++) begin
         exp_flag = step(exp_flag, 1'b0);
         push(1'b0, base + HOLD + k * RPT, exp_flag);
      end
`endif
      release_after(28);

      repeat (20) @(posedge clk);
      check_val("pending expected pulses", sb.size(), 0);
      check_val("final menu_flag", int'(menu_flag), exp_flag);
      check_val("single-item moves", move_cnt1, 0);
      check_val("single-item selects", sel_cnt1, n_sel);
      check_val("flag range violations", range_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
